// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: request/strobe/data out, read data and ready back.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues one data-memory access per load/store, stalls upstream
// until the response returns, and fills the MEM/WB register.
module mem_access_stage (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               EXMEM_AluRES,
    input  logic [31:0]               rs2,
    input  logic                      EXMEM_WriteBack,
    input  logic                      EXMEM_MemoryRead,
    input  logic                      EXMEM_MemoryWrite,
    input  logic                      EXMEM_U_UJ_Load,
    input  logic [4:0]                EXMEM_rd,
    input  logic [31:0]               EXMEM_U_UJ_Load_val,
    input  logic [2:0]                EXMEM_funct3,
    mem_access_stage_if.master        dmem,
    output logic                      mem_stall,
    output logic                      MEMWB_WriteBack,
    output logic [4:0]                MEMWB_rd,
    output logic [31:0]               MEMWB_result,
    output logic                      misaligned_fault
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_wb, r_we;
    logic [3:0]  r_wstrb;

    logic        w_is_mem, w_one_op, w_aligned, w_start, w_fault;
    logic [31:0] w_alu_res, w_st_data, w_ld_data;
    logic [3:0]  w_st_strb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_is_mem  = EXMEM_MemoryRead | EXMEM_MemoryWrite;
    assign w_one_op  = EXMEM_MemoryRead ^ EXMEM_MemoryWrite;
    assign w_alu_res = EXMEM_U_UJ_Load ? EXMEM_U_UJ_Load_val : EXMEM_AluRES;

    always_comb begin
        w_aligned = 1'b1;
        case (EXMEM_funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~EXMEM_AluRES[0];
            default: w_aligned = (EXMEM_AluRES[1:0] == 2'b00);
        endcase
    end

    assign w_start = (r_state == IDLE) & w_one_op & w_aligned;
    assign w_fault = (r_state == IDLE) & w_is_mem & ~(w_one_op & w_aligned);

    // Store lane replication: the memory picks bytes by strobe, so data is copied to every lane.
    always_comb begin
        w_st_strb = 4'b1111;
        w_st_data = rs2;
        case (EXMEM_funct3[1:0])
            2'b00: begin
                w_st_strb = 4'b0001 << EXMEM_AluRES[1:0];
                w_st_data = {4{rs2[7:0]}};
            end
            2'b01: begin
                w_st_strb = EXMEM_AluRES[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{rs2[15:0]}};
            end
            default: begin
                w_st_strb = 4'b1111;
                w_st_data = rs2;
            end
        endcase
    end

    always_comb begin
        w_byte = r_rdata[7:0];
        case (r_addr[1:0])
            2'b00: w_byte = r_rdata[7:0];
            2'b01: w_byte = r_rdata[15:8];
            2'b10: w_byte = r_rdata[23:16];
            2'b11: w_byte = r_rdata[31:24];
        endcase
        w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = r_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = ACCESS;
            ACCESS:  if (dmem.dmem_ready) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign mem_stall       = w_start | (r_state == ACCESS);
    assign dmem.dmem_req   = (r_state == ACCESS);
    assign dmem.dmem_we    = dmem.dmem_req & r_we;
    assign dmem.dmem_wstrb = dmem.dmem_req ? r_wstrb : 4'b0000;
    assign dmem.dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem.dmem_wdata = r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_rdata          <= '0;
            r_funct3         <= '0;
            r_rd             <= '0;
            r_wb             <= 1'b0;
            r_we             <= 1'b0;
            r_wstrb          <= '0;
            MEMWB_WriteBack  <= 1'b0;
            MEMWB_rd         <= '0;
            MEMWB_result     <= '0;
            misaligned_fault <= 1'b0;
        end else begin
            r_state          <= w_next;
            misaligned_fault <= w_fault;
            case (r_state)
                IDLE: begin
                    // Any memory op (started or faulted) leaves a bubble behind it.
                    MEMWB_WriteBack <= w_is_mem ? 1'b0 : EXMEM_WriteBack;
                    MEMWB_rd        <= EXMEM_rd;
                    MEMWB_result    <= w_alu_res;
                    if (w_start) begin
                        r_addr   <= EXMEM_AluRES;
                        r_funct3 <= EXMEM_funct3;
                        r_rd     <= EXMEM_rd;
                        r_wb     <= EXMEM_WriteBack;
                        r_we     <= EXMEM_MemoryWrite;
                        r_wstrb  <= EXMEM_MemoryWrite ? w_st_strb : 4'b0000;
                        r_wdata  <= w_st_data;
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ready) r_rdata <= dmem.dmem_rdata;
                end
                RESP: begin
                    MEMWB_WriteBack <= r_we ? 1'b0 : r_wb;
                    MEMWB_rd        <= r_rd;
                    MEMWB_result    <= w_ld_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port EXMEM_AluRES, input, 32 bits: effective address or ALU result.
REQ-004 The block SHALL have the port rs2, input, 32 bits: store data.
REQ-005 The block SHALL have the inputs EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite and EXMEM_U_UJ_Load, each 1 bit: control flags.
REQ-006 The block SHALL have the port EXMEM_rd, input, 5 bits: destination register.
REQ-007 The block SHALL have the port EXMEM_U_UJ_Load_val, input, 32 bits: U/UJ immediate result.
REQ-008 The block SHALL have the port EXMEM_funct3, input, 3 bits: access size and sign.
REQ-009 The block SHALL have the memory-side outputs dmem_req (1), dmem_we (1), dmem_addr (32, word-aligned), dmem_wdata (32) and dmem_wstrb (4).
REQ-010 The block SHALL have the memory-side inputs dmem_rdata (32) and dmem_ready (1).
REQ-011 The block SHALL have the output mem_stall, 1 bit: holds the EX/MEM register and all upstream stages.
REQ-012 The block SHALL have the outputs MEMWB_WriteBack (1), MEMWB_rd (5) and MEMWB_result (32), all registered.
REQ-013 The block SHALL have the output misaligned_fault, 1 bit, registered, a one-cycle pulse.

Function
REQ-014 The block SHALL implement an FSM with three states: IDLE, ACCESS and RESP.
REQ-015 In IDLE with neither Read nor Write set, the block SHALL load MEM/WB on the next edge with WriteBack = EXMEM_WriteBack, rd = EXMEM_rd, and result = EXMEM_U_UJ_Load ? EXMEM_U_UJ_Load_val : EXMEM_AluRES; mem_stall SHALL be 0.
REQ-016 In IDLE with exactly one of Read or Write set and the access aligned, the block SHALL assert mem_stall combinationally, latch address, funct3, rd, WriteBack, strobe and write data, load a MEM/WB bubble (WriteBack=0), and go to ACCESS.
REQ-017 Alignment: funct3[1:0]=01 SHALL require addr[0]=0, and funct3[1:0]=1x SHALL require addr[1:0]=00; byte accesses SHALL always be aligned.
REQ-018 For a misaligned access, or with Read and Write both set, the block SHALL issue no memory request and set misaligned_fault=1 for one cycle; MEM/WB SHALL be a bubble and mem_stall SHALL be 0.
REQ-019 In ACCESS, dmem_req SHALL be 1 and mem_stall SHALL be 1; dmem_addr = {addr[31:2],2'b00}; dmem_we, dmem_wdata and dmem_wstrb SHALL be held stable until dmem_ready.
REQ-020 In ACCESS, when dmem_ready=1 the block SHALL capture dmem_rdata and go to RESP; with dmem_ready=0 it SHALL remain in ACCESS, with no timeout.
REQ-021 Stores SHALL use these strobe and data encodings: SB wstrb = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}; SH wstrb = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}; SW wstrb = 1111, wdata = rs2.
REQ-022 Loads SHALL select the lane by addr[1:0]: 000 LB sign-extends, 100 LBU zero-extends, 001 LH sign-extends, 101 LHU zero-extends, and 010 LW is unmodified; funct3 values 011, 110 and 111 SHALL be treated as word accesses.
REQ-023 In RESP, mem_stall SHALL be 0; on the edge the block SHALL load MEM/WB with the extended load data (load) or a bubble (store; WriteBack forced to 0), and go to IDLE.
REQ-024 In RESP, the block SHALL not sample the EX/MEM inputs; the next instruction SHALL be evaluated in IDLE.
REQ-025 Stall length SHALL be 2 + N cycles, where N is the number of ACCESS cycles with dmem_ready=0; MEM/WB SHALL be valid on the edge ending RESP.
REQ-026 When dmem_req=0, dmem_we and dmem_wstrb SHALL be 0.

Reset
REQ-027 With reset=1 on an edge, the block SHALL set state to IDLE and set MEMWB_WriteBack, MEMWB_rd, MEMWB_result and misaligned_fault to 0; dmem_req and mem_stall SHALL be 0 from the following cycle.
REQ-028 On reset during ACCESS or RESP, the block SHALL abandon the transaction and not update MEM/WB with its result; an acknowledgement arriving later SHALL be ignored.
REQ-029 reset SHALL take priority over all other inputs.

Verification
REQ-030 ALU op, AluRES=0x00000010, WriteBack=1, rd=5 -> next edge MEMWB_result=0x10, rd=5, WriteBack=1; mem_stall never 1.
REQ-031 LB at addr 0x103, dmem_ready in first ACCESS cycle, rdata=0x80FF1234 -> stall for 2 cycles; MEMWB_result=0xFFFFFF80.
REQ-032 SH at addr 0x202, rs2=0x0000BEEF, ready after 3 wait cycles -> wstrb=1100, wdata=0xBEEFBEEF, addr=0x200; stall for 5 cycles; MEMWB_WriteBack=0.
REQ-033 LW at addr 0x101 -> misaligned_fault pulses once, dmem_req stays 0, MEMWB_WriteBack=0, no stall.
REQ-034 LHU at addr 0x2, rdata=0xABCD0000 -> MEMWB_result=0x0000ABCD; back-to-back second load accepted in the cycle after RESP.
REQ-035 Reset asserted in the second ACCESS cycle -> dmem_req=0 next cycle, state IDLE, MEM/WB registers all zero.
